mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 1024x32 BRAM `Memory` block.
- Requesters: instruction fetch (read-only) and data load/store (read/write with byte enables).
- The memory has no byte lanes, so partial writes are sequenced as read-modify-write (RMW).
- Owns the memory's address, write-data and active-low write-enable pins, and accounts for its 1-cycle registered read latency.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data requester handshakes and Memory pins around mem_arbiter
interface mem_arbiter_if #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
);
    logic                    if_req_i;
    logic [31:0]             if_addr_i;
    logic                    if_gnt_o;
    logic                    if_rvalid_o;
    logic [DATA_WIDTH-1:0]   if_rdata_o;
    logic                    d_req_i;
    logic                    d_we_i;
    logic [DATA_WIDTH/8-1:0] d_be_i;
    logic [31:0]             d_addr_i;
    logic [DATA_WIDTH-1:0]   d_wdata_i;
    logic                    d_gnt_o;
    logic                    d_rvalid_o;
    logic [DATA_WIDTH-1:0]   d_rdata_o;
    logic                    d_wack_o;
    logic [WORDS-1:0]        mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_data_o;
    logic                    mem_wr_no;
    logic [DATA_WIDTH-1:0]   mem_data_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i, mem_data_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, d_wack_o,
               mem_addr_o, mem_data_o, mem_wr_no
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i, mem_data_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, d_wack_o,
               mem_addr_o, mem_data_o, mem_wr_no
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter sequencing reads, full writes and RMW partial writes into a 1-cycle-latency BRAM
module mem_arbiter #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
) (
    input logic         clk_i,
    input logic         reset_ni,
    mem_arbiter_if.slave bus
);
    localparam int BE = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RD, RSP, WR} state_t;

    state_t                state, state_nx;
    logic                  src_d, we_q, last_d, wr_n;
    logic                  gnt_if, gnt_d, full;
    logic [BE-1:0]         be_q;
    logic [WORDS-1:0]      addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, mem_data_q, merged, if_hold, d_hold;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{bus.if_addr_i[31:WORDS+2], bus.if_addr_i[1:0],
                                bus.d_addr_i[31:WORDS+2], bus.d_addr_i[1:0]};

    always_comb begin
        gnt_if = reset_ni && state == IDLE && bus.if_req_i && (!bus.d_req_i || last_d);
        gnt_d = reset_ni && state == IDLE && bus.d_req_i && (!bus.if_req_i || !last_d);
        full = &bus.d_be_i;
        merged = bus.mem_data_i;
        for (int i = 0; i < BE; i++)
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.mem_data_i[8*i +: 8];
        state_nx = state == IDLE ? (gnt_d && bus.d_we_i && full ? WR : (gnt_if || gnt_d) ? RD : IDLE) :
                   state == RD   ? RSP :
                   state == RSP && we_q ? WR : IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            src_d      <= 1'b0;
            we_q       <= 1'b0;
            last_d     <= 1'b1;
            wr_n       <= 1'b1;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_data_q <= '0;
            if_hold    <= '0;
            d_hold     <= '0;
        end else begin
            state <= state_nx;
            if (gnt_if || gnt_d) begin
                src_d   <= gnt_d;
                we_q    <= gnt_d && bus.d_we_i;
                be_q    <= bus.d_be_i;
                wdata_q <= bus.d_wdata_i;
                addr_q  <= gnt_d ? bus.d_addr_i[WORDS+1:2] : bus.if_addr_i[WORDS+1:2];
                last_d  <= gnt_d;
            end
            if (gnt_d && bus.d_we_i && full)
                mem_data_q <= bus.d_wdata_i;
            if (state == RSP && we_q)
                mem_data_q <= merged;
            if (state == RSP && !we_q && src_d)
                d_hold <= bus.mem_data_i;
            if (state == RSP && !we_q && !src_d)
                if_hold <= bus.mem_data_i;
            // registered strobe: only a full write or a nonzero-be RMW reaches WR with a write
            wr_n <= !(state_nx == WR && (state == IDLE || |be_q));
        end
    end

    assign bus.if_gnt_o    = gnt_if;
    assign bus.d_gnt_o     = gnt_d;
    assign bus.if_rvalid_o = state == RSP && !we_q && !src_d;
    assign bus.d_rvalid_o  = state == RSP && !we_q && src_d;
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_data_i : if_hold;
    assign bus.d_rdata_o   = bus.d_rvalid_o ? bus.mem_data_i : d_hold;
    assign bus.d_wack_o    = state == WR;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_data_o  = mem_data_q;
    assign bus.mem_wr_no   = wr_n;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: BRAM model plus scoreboard of expected responses, table-driven transactions and reset/arbitration sequences
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WORDS(10), .DATA_WIDTH(32)) b();
    mem_arbiter #(.WORDS(10), .DATA_WIDTH(32)) dut (.clk_i(clk), .reset_ni(reset_ni), .bus(b));

    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [31:0] exp_mem [0:1023] = '{default: 32'h0};

    always @(posedge clk) begin
        if (!b.mem_wr_no) mem[b.mem_addr_o] <= b.mem_data_o;
        b.mem_data_i <= mem[b.mem_addr_o];
    end

    typedef struct {
        int          kind;
        logic [31:0] d;
        logic [9:0]  a;
        logic        wr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        src;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb[$];
    int          glog[$];
    int          checks = 0, errors = 0, cyc = 0, wr_cycles = 0;
    logic [31:0] last_data = 0, hold_if = 0, hold_d = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? w[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        logic [2:0] resp;
        exp_t       e;
        if (!reset_ni) begin
            sb.delete();
            hold_if = 0;
            hold_d = 0;
        end else begin
            resp = {b.if_rvalid_o, b.d_rvalid_o, b.d_wack_o};
            if (resp != 0) begin
                if ($countones(resp) != 1 || sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %b with %0d pending, required one expected response", resp, sb.size());
                end else begin
                    e = sb.pop_front();
                    chk("resp_kind", resp, e.kind == 0 ? 3'b100 : e.kind == 1 ? 3'b010 : 3'b001);
                    chk("latency", cyc, e.cyc);
                    if (b.if_rvalid_o) begin
                        chk("if_rdata", b.if_rdata_o, e.d);
                        last_data = b.if_rdata_o;
                        hold_if = b.if_rdata_o;
                    end
                    if (b.d_rvalid_o) begin
                        chk("d_rdata", b.d_rdata_o, e.d);
                        last_data = b.d_rdata_o;
                        hold_d = b.d_rdata_o;
                    end
                    if (b.d_wack_o) begin
                        chk("wr_strobe", b.mem_wr_no, !e.wr);
                        if (e.wr) begin
                            chk("wr_addr", b.mem_addr_o, e.a);
                            chk("wr_data", b.mem_data_o, e.d);
                            exp_mem[e.a] = e.d;
                        end
                        last_data = exp_mem[e.a];
                    end
                end
            end
            if (!b.if_rvalid_o) chk("if_rdata_hold", b.if_rdata_o, hold_if);
            if (!b.d_rvalid_o) chk("d_rdata_hold", b.d_rdata_o, hold_d);
            if (!b.mem_wr_no) begin
                wr_cycles++;
                chk("wack_with_write", b.d_wack_o, 1);
            end
            chk("both_gnt", b.if_gnt_o && b.d_gnt_o, 0);
            if ((b.if_gnt_o || b.d_gnt_o) && (sb.size() != 0 || resp != 0)) begin
                checks++;
                errors++;
                $display("FAIL gnt_busy: got gnt with %0d pending, required no gnt outside idle", sb.size());
            end
            if (b.if_gnt_o && b.if_req_i) begin
                glog.push_back(0);
                sb.push_back('{0, exp_mem[b.if_addr_i[11:2]], b.if_addr_i[11:2], 1'b0, cyc + 2});
            end
            if (b.d_gnt_o && b.d_req_i) begin
                glog.push_back(1);
                if (!b.d_we_i)
                    sb.push_back('{1, exp_mem[b.d_addr_i[11:2]], b.d_addr_i[11:2], 1'b0, cyc + 2});
                else
                    sb.push_back('{2, merge(exp_mem[b.d_addr_i[11:2]], b.d_wdata_i, b.d_be_i),
                                   b.d_addr_i[11:2], b.d_be_i != 0, cyc + (&b.d_be_i ? 1 : 3)});
            end
        end
    end

    task automatic run(input int idx, input vec_t v);
        int n;
        @(posedge clk);
        #1;
        b.d_we_i = v.we;
        b.d_be_i = v.be;
        b.d_addr_i = v.addr;
        b.if_addr_i = v.addr;
        b.d_wdata_i = v.wdata;
        if (v.src) b.d_req_i = 1'b1;
        else b.if_req_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b.if_gnt_o || b.d_gnt_o) && n < 20);
        chk($sformatf("vec%0d_gnt_src", idx), {b.if_gnt_o, b.d_gnt_o}, v.src ? 2'b01 : 2'b10);
        @(posedge clk);
        #1;
        b.if_req_i = 1'b0;
        b.d_req_i = 1'b0;
        b.d_wdata_i = 32'hA5A5_A5A5;
        b.d_be_i = 4'hF;
        b.d_addr_i = 32'h0;
        b.if_addr_i = 32'h0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("vec%0d_pending", idx), sb.size(), 0);
        chk($sformatf("vec%0d_result", idx), last_data, v.exp);
    endtask

    vec_t vt[14];

    initial begin
        int n;
        vt[0]  = '{1, 1, 4'hF, 32'h0000_000C, 32'h5544_3312, 32'h5544_3312};
        vt[1]  = '{0, 0, 4'h0, 32'h0000_000C, 32'h0,         32'h5544_3312};
        vt[2]  = '{1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[3]  = '{1, 0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vt[4]  = '{1, 1, 4'hF, 32'h0000_0028, 32'h5544_3312, 32'h5544_3312};
        vt[5]  = '{1, 1, 4'h2, 32'h0000_0028, 32'h0000_AB00, 32'h5544_AB12};
        vt[6]  = '{1, 0, 4'h0, 32'h0000_002A, 32'h0,         32'h5544_AB12};
        vt[7]  = '{1, 1, 4'hF, 32'h0000_0004, 32'h0000_0004, 32'h0000_0004};
        vt[8]  = '{1, 1, 4'h0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0004};
        vt[9]  = '{0, 0, 4'h0, 32'h0000_0004, 32'h0,         32'h0000_0004};
        vt[10] = '{1, 1, 4'h9, 32'h0000_1010, 32'h1122_3344, 32'h11AD_BE44};
        vt[11] = '{0, 0, 4'h0, 32'h0000_0010, 32'h0,         32'h11AD_BE44};
        vt[12] = '{1, 1, 4'h4, 32'h0000_000C, 32'h00AA_0000, 32'h55AA_3312};
        vt[13] = '{1, 0, 4'h0, 32'h0000_000C, 32'h0,         32'h55AA_3312};

        b.if_req_i = 1'b1;
        b.if_addr_i = 32'h0;
        b.d_req_i = 1'b1;
        b.d_we_i = 1'b0;
        b.d_be_i = 4'h0;
        b.d_addr_i = 32'h0;
        b.d_wdata_i = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {b.if_gnt_o, b.d_gnt_o}, 0);
        chk("rst_wr_n", b.mem_wr_no, 1);
        chk("rst_addr", b.mem_addr_o, 0);
        chk("rst_data", b.mem_data_o, 0);
        chk("rst_valid", {b.if_rvalid_o, b.d_rvalid_o, b.d_wack_o}, 0);
        chk("rst_rdata", b.if_rdata_o | b.d_rdata_o, 0);
        @(posedge clk);
        #1 reset_ni = 1'b1;

        n = 0;
        while (glog.size() < 4 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        b.if_req_i = 1'b0;
        b.d_req_i = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("rr_count", glog.size() >= 4, 1);
        if (glog.size() >= 4)
            chk("rr_order", {glog[0][0], glog[1][0], glog[2][0], glog[3][0]}, 4'b0101);

        for (int i = 0; i < 14; i++) run(i, vt[i]);

        @(posedge clk);
        #1;
        b.d_req_i = 1'b1;
        b.d_we_i = 1'b1;
        b.d_be_i = 4'h1;
        b.d_addr_i = 32'h28;
        b.d_wdata_i = 32'h0000_00FF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b.d_gnt_o && n < 20);
        chk("abort_gnt", b.d_gnt_o, 1);
        @(posedge clk);
        #1 b.d_req_i = 1'b0;
        @(posedge clk);
        #1 reset_ni = 1'b0;
        b.d_req_i = 1'b1;
        #1;
        chk("abort_wr_n", b.mem_wr_no, 1);
        chk("abort_outs", {b.if_gnt_o, b.d_gnt_o, b.if_rvalid_o, b.d_rvalid_o, b.d_wack_o}, 0);
        chk("abort_addr", b.mem_addr_o, 0);
        chk("abort_rdata", b.if_rdata_o | b.d_rdata_o, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_hold_wr_n", b.mem_wr_no, 1);
        reset_ni = 1'b1;
        b.d_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem10", mem[10], 32'h5544_AB12);
        chk("abort_pending", sb.size(), 0);
        run(14, '{1, 0, 4'h0, 32'h0000_0028, 32'h0, 32'h5544_AB12});
        chk("be0_mem1", mem[1], 32'h0000_0004);
        chk("wr_cycles", wr_cycles, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
